// File: rtl/ltsm_sbinit_ctrl.sv
// -----------------------------------------------------------------------------
// ltsm_sbinit_ctrl
//
// SBINIT sub-state controller of the link training state machine. While the
// LTSM holds start_i high it sends the sideband clock pattern until the partner's
// pattern is detected. It then exchanges the out-of-reset message and performs
// the SBINIT done request/response handshake. Completion is reported on done_o
// and an expired cycle budget on timeout_o. Dropping start_i returns to IDLE
// from any state.
//
// Ports
//   clk_100MHz          sideband clock
//   reset               asynchronous, active-high reset
//   start_i             level, high while the LTSM is in SBINIT
//   pattern_detected_i  pulse from the SB RX clock-pattern detector
//   rx_msg_valid_i      strobe, a decoded SB message is on rx_msg_code_i
//   rx_msg_code_i       codex of the received message
//   tx_msg_ready_i      SB encoder accepts the offered message this cycle
//   pattern_tx_en_o     SB TX sends the clock pattern while high
//   tx_msg_valid_o      tx message request, held until accepted
//   tx_msg_code_o       codex of the tx message, 8'h00 while not valid
//   done_o              level, SBINIT complete
//   timeout_o           level, SBINIT failed
// -----------------------------------------------------------------------------
module ltsm_sbinit_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES   = 800000,
  parameter logic [7:0]  MSG_OUT_OF_RESET = 8'h01,
  parameter logic [7:0]  MSG_DONE_REQ     = 8'h02,
  parameter logic [7:0]  MSG_DONE_RESP    = 8'h03
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       start_i,
  input  logic       pattern_detected_i,
  input  logic       rx_msg_valid_i,
  input  logic [7:0] rx_msg_code_i,
  input  logic       tx_msg_ready_i,
  output logic       pattern_tx_en_o,
  output logic       tx_msg_valid_o,
  output logic [7:0] tx_msg_code_o,
  output logic       done_o,
  output logic       timeout_o
);

  typedef enum logic [2:0] {
    IDLE,
    PATTERN,
    OOR_TX,
    OOR_WAIT,
    DONE_TX,
    DONE_WAIT,
    COMPLETE,
    TIMEOUT
  } sbinitState_t;

  // Counter value on which the budget is exhausted.
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  sbinitState_t state, stateNext;
  logic         rxOor, rxOorNext;
  logic         rxReq, rxReqNext;
  logic         rxResp, rxRespNext;
  logic         respSent, respSentNext;
  logic [19:0]  cycleCount, cycleCountNext;
  logic         respOffer;
  logic         respAccept;

  // The done response is offered only in DONE_WAIT, once the partner's request
  // has been seen, and only once.
  assign respOffer  = (state == DONE_WAIT) && rxReq && !respSent;
  assign respAccept = respOffer && tx_msg_ready_i;

  // NOTE: the reset branch is asynchronous, so reset forces IDLE and therefore
  // all-zero outputs immediately, without waiting for a clock edge.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rxOor      <= 1'b0;
      rxReq      <= 1'b0;
      rxResp     <= 1'b0;
      respSent   <= 1'b0;
      cycleCount <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values present before the edge, independent of statement order.
      state      <= stateNext;
      rxOor      <= rxOorNext;
      rxReq      <= rxReqNext;
      rxResp     <= rxRespNext;
      respSent   <= respSentNext;
      cycleCount <= cycleCountNext;
    end
  end

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path through
    // the block leaves one unassigned, which would infer a latch.
    stateNext      = state;
    rxOorNext      = rxOor;
    rxReqNext      = rxReq;
    rxRespNext     = rxResp;
    respSentNext   = respSent;
    cycleCountNext = cycleCount;

    if (!start_i) begin
      // Leaving SBINIT: any pending request is abandoned and ready is ignored.
      stateNext      = IDLE;
      rxOorNext      = 1'b0;
      rxReqNext      = 1'b0;
      rxRespNext     = 1'b0;
      respSentNext   = 1'b0;
      cycleCountNext = '0;
    end else begin
      // Sticky receive flags. They are registered, so a message arriving on a
      // transition edge is acted on one cycle later but never dropped.
      if (state != IDLE && rx_msg_valid_i) begin
        if (rx_msg_code_i == MSG_OUT_OF_RESET) rxOorNext  = 1'b1;
        if (rx_msg_code_i == MSG_DONE_REQ)     rxReqNext  = 1'b1;
        if (rx_msg_code_i == MSG_DONE_RESP)    rxRespNext = 1'b1;
      end

      case (state)
        IDLE: begin
          rxOorNext      = 1'b0;
          rxReqNext      = 1'b0;
          rxRespNext     = 1'b0;
          respSentNext   = 1'b0;
          cycleCountNext = '0;
          stateNext      = PATTERN;
        end
        PATTERN:   if (pattern_detected_i) stateNext = OOR_TX;
        OOR_TX:    if (tx_msg_ready_i)     stateNext = OOR_WAIT;
        OOR_WAIT:  if (rxOor)              stateNext = DONE_TX;
        DONE_TX:   if (tx_msg_ready_i)     stateNext = DONE_WAIT;
        DONE_WAIT: begin
          if (respAccept) respSentNext = 1'b1;
          // Completing on the accepting edge itself saves one cycle.
          if (rxResp && (respSent || respAccept)) stateNext = COMPLETE;
        end
        COMPLETE:  stateNext = COMPLETE;
        TIMEOUT:   stateNext = TIMEOUT;
        default:   stateNext = IDLE;
      endcase

      // The budget runs in every active state; it overrides the case above.
      if (state inside {PATTERN, OOR_TX, OOR_WAIT, DONE_TX, DONE_WAIT}) begin
        cycleCountNext = cycleCount + 20'd1;
        if (cycleCountNext == TIMEOUT_LAST) stateNext = TIMEOUT;
      end
    end
  end

  // Outputs decode only registered state and flags, never a raw input, so they
  // change only right after a clock edge.
  assign pattern_tx_en_o = (state == PATTERN);
  assign done_o          = (state == COMPLETE);
  assign timeout_o       = (state == TIMEOUT);
  assign tx_msg_valid_o  = (state == OOR_TX) || (state == DONE_TX) || respOffer;

  always_comb begin
    tx_msg_code_o = 8'h00;
    if (state == OOR_TX)  tx_msg_code_o = MSG_OUT_OF_RESET;
    if (state == DONE_TX) tx_msg_code_o = MSG_DONE_REQ;
    if (respOffer)        tx_msg_code_o = MSG_DONE_RESP;
  end

endmodule

// File: tb/tb_ltsm_sbinit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ltsm_sbinit_ctrl
//
// Self-checking bench for ltsm_sbinit_ctrl.
//   dutA/dutB : two controllers joined by an ideal 1-cycle message channel
//   dutC      : directed stimulus; its tx transfers are checked against a queue
//               of expected codes pushed as each scenario is driven
//   dutT      : TIMEOUT_CYCLES = 100, pattern never detected
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ltsm_sbinit_ctrl;

  localparam logic [7:0] OOR   = 8'h01;
  localparam logic [7:0] REQ   = 8'h02;
  localparam logic [7:0] RESP  = 8'h03;
  localparam logic [7:0] BOGUS = 8'hFF;

  logic clk_100MHz = 1'b0;
  logic reset      = 1'b1;
  always #5 clk_100MHz = ~clk_100MHz;

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkValue(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  // ---------------- dutA / dutB cross-connected ----------------
  logic       startAB = 1'b0;
  logic       patEnA, txValidA, doneA, timeoutA;
  logic       patEnB, txValidB, doneB, timeoutB;
  logic [7:0] txCodeA, txCodeB;
  logic       abValid, baValid;
  logic [7:0] abCode, baCode;

  always @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      abValid <= 1'b0; abCode <= 8'h00;
      baValid <= 1'b0; baCode <= 8'h00;
    end else begin
      abValid <= txValidA; abCode <= txCodeA;
      baValid <= txValidB; baCode <= txCodeB;
    end
  end

  // The partner's pattern is detected as soon as it is sent.
  ltsm_sbinit_ctrl dutA (
    .clk_100MHz(clk_100MHz), .reset(reset), .start_i(startAB),
    .pattern_detected_i(patEnB), .rx_msg_valid_i(baValid), .rx_msg_code_i(baCode),
    .tx_msg_ready_i(1'b1), .pattern_tx_en_o(patEnA), .tx_msg_valid_o(txValidA),
    .tx_msg_code_o(txCodeA), .done_o(doneA), .timeout_o(timeoutA));

  ltsm_sbinit_ctrl dutB (
    .clk_100MHz(clk_100MHz), .reset(reset), .start_i(startAB),
    .pattern_detected_i(patEnA), .rx_msg_valid_i(abValid), .rx_msg_code_i(abCode),
    .tx_msg_ready_i(1'b1), .pattern_tx_en_o(patEnB), .tx_msg_valid_o(txValidB),
    .tx_msg_code_o(txCodeB), .done_o(doneB), .timeout_o(timeoutB));

  // ---------------- dutC directed ----------------
  logic       startC = 1'b0, patC = 1'b0, rxValidC = 1'b0, readyC = 1'b1;
  logic [7:0] rxCodeC = 8'h00;
  logic       patEnC, txValidC, doneC, timeoutC;
  logic [7:0] txCodeC;

  ltsm_sbinit_ctrl dutC (
    .clk_100MHz(clk_100MHz), .reset(reset), .start_i(startC),
    .pattern_detected_i(patC), .rx_msg_valid_i(rxValidC), .rx_msg_code_i(rxCodeC),
    .tx_msg_ready_i(readyC), .pattern_tx_en_o(patEnC), .tx_msg_valid_o(txValidC),
    .tx_msg_code_o(txCodeC), .done_o(doneC), .timeout_o(timeoutC));

  // ---------------- dutT short timeout ----------------
  logic       startT = 1'b0;
  logic       patEnT, txValidT, doneT, timeoutT;
  logic [7:0] txCodeT;

  ltsm_sbinit_ctrl #(.TIMEOUT_CYCLES(100)) dutT (
    .clk_100MHz(clk_100MHz), .reset(reset), .start_i(startT),
    .pattern_detected_i(1'b0), .rx_msg_valid_i(1'b0), .rx_msg_code_i(8'h00),
    .tx_msg_ready_i(1'b1), .pattern_tx_en_o(patEnT), .tx_msg_valid_o(txValidT),
    .tx_msg_code_o(txCodeT), .done_o(doneT), .timeout_o(timeoutT));

  // ---------------- scoreboard on dutC transfers ----------------
  logic [7:0] expCodes[$];

  always @(negedge clk_100MHz) begin
    logic [7:0] expCode;
    if (!reset) begin
      if (txValidC && readyC) begin
        if (expCodes.size() == 0) begin
          checkValue("sb_extra_tx", txCodeC, 8'h00);
        end else begin
          expCode = expCodes.pop_front();
          checkValue("sb_tx_code", txCodeC, expCode);
        end
      end
      if (!txValidC) checkValue("code_zero_when_idle", txCodeC, 8'h00);
      checkValue("done_timeout_excl", doneC & timeoutC, 1'b0);
    end
  end

  task automatic driveC(input logic valid, input logic [7:0] code, input logic pat);
    rxValidC = valid;
    rxCodeC  = valid ? code : 8'h00;
    patC     = pat;
  endtask

  initial begin
    #400us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int firstA, firstB, firstT;

    // ---------------- reset state ----------------
    #1;
    checkValue("rst_pat_en", patEnC, 1'b0);
    checkValue("rst_tx_valid", txValidC, 1'b0);
    checkValue("rst_tx_code", txCodeC, 8'h00);
    checkValue("rst_done", doneC, 1'b0);
    checkValue("rst_timeout", timeoutC, 1'b0);
    checkValue("rst_doneA", doneA, 1'b0);
    checkValue("rst_timeoutT", timeoutT, 1'b0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // ---------------- two instances back to back ----------------
    startAB = 1'b1;
    firstA = 0; firstB = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (doneA && firstA == 0) firstA = e;
      if (doneB && firstB == 0) firstB = e;
      checkValue("ab_timeoutA", timeoutA, 1'b0);
      checkValue("ab_timeoutB", timeoutB, 1'b0);
    end
    checkValue("ab_doneA_by12", doneA, 1'b1);
    checkValue("ab_doneB_by12", doneB, 1'b1);
    checkValue("ab_doneA_held", 32'(firstA != 0), 1);
    startAB = 1'b0;
    tick();
    checkValue("ab_doneA_cleared", doneA, 1'b0);

    // ---------------- minimum latency, everything immediate ----------------
    expCodes.push_back(OOR); expCodes.push_back(REQ); expCodes.push_back(RESP);
    startC = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      case (e)
        2:       driveC(1'b1, OOR, 1'b1);
        3:       driveC(1'b1, REQ, 1'b0);
        4:       driveC(1'b1, RESP, 1'b0);
        default: driveC(1'b0, 8'h00, 1'b0);
      endcase
      tick();
      if (e == 1) checkValue("ml_pat_rise", patEnC, 1'b1);
      if (e == 5) checkValue("ml_done_e5", doneC, 1'b0);
      if (e == 6) checkValue("ml_done_e6", doneC, 1'b1);
    end
    driveC(1'b0, 8'h00, 1'b0);
    checkValue("ml_drained", expCodes.size(), 0);
    startC = 1'b0;
    tick();
    checkValue("ml_done_cleared", doneC, 1'b0);

    // ------- early partner messages, late detection, unknown codes mixed in -------
    expCodes.push_back(OOR); expCodes.push_back(REQ); expCodes.push_back(RESP);
    startC = 1'b1;
    for (int e = 1; e <= 44; e++) begin
      case (e)
        4:       driveC(1'b1, OOR, 1'b0);
        6:       driveC(1'b1, REQ, 1'b0);
        20:      driveC(1'b0, 8'h00, 1'b1);
        40:      driveC(1'b1, RESP, 1'b0);
        default: driveC(e % 2 == 1, BOGUS, 1'b0);
      endcase
      tick();
      if (e == 19) checkValue("ep_pat_before", patEnC, 1'b1);
      if (e == 20) checkValue("ep_pat_fall", patEnC, 1'b0);
      if (e == 30) checkValue("ep_wait_resp", doneC, 1'b0);
      if (e == 40) checkValue("ep_done_e40", doneC, 1'b0);
      if (e == 41) checkValue("ep_done_e41", doneC, 1'b1);
      if (e == 44) checkValue("ep_done_held", doneC, 1'b1);
    end
    driveC(1'b0, 8'h00, 1'b0);
    checkValue("ep_timeout", timeoutC, 1'b0);
    checkValue("ep_drained", expCodes.size(), 0);
    startC = 1'b0;
    tick();

    // ---------------- encoder stalls in OOR_TX ----------------
    expCodes.push_back(OOR);
    readyC = 1'b0;
    startC = 1'b1;
    tick();
    driveC(1'b0, 8'h00, 1'b1);
    tick();
    driveC(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) begin
      checkValue("st_valid_held", txValidC, 1'b1);
      checkValue("st_code_held", txCodeC, OOR);
      tick();
    end
    checkValue("st_valid_last", txValidC, 1'b1);
    readyC = 1'b1;
    tick();
    checkValue("st_valid_after", txValidC, 1'b0);
    checkValue("st_one_transfer", expCodes.size(), 0);
    tick(); tick();
    checkValue("st_no_retx", txValidC, 1'b0);
    startC = 1'b0;
    tick();

    // ------------- start dropped in DONE_WAIT, then restarted -------------
    expCodes.push_back(OOR); expCodes.push_back(REQ);
    startC = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      case (e)
        2:       driveC(1'b1, OOR, 1'b1);
        3:       driveC(1'b1, REQ, 1'b0);
        4:       driveC(1'b1, RESP, 1'b0);
        default: driveC(1'b0, 8'h00, 1'b0);
      endcase
      if (e == 6) readyC = 1'b0;
      tick();
    end
    checkValue("dw_resp_offered", txValidC, 1'b1);
    checkValue("dw_resp_code", txCodeC, RESP);
    checkValue("dw_not_done", doneC, 1'b0);
    startC = 1'b0;
    tick();
    checkValue("dw_withdrawn", txValidC, 1'b0);
    readyC = 1'b1;
    startC = 1'b1;
    tick();
    checkValue("rs_pattern", patEnC, 1'b1);
    expCodes.push_back(OOR); expCodes.push_back(REQ);
    driveC(1'b0, 8'h00, 1'b1);
    tick();
    driveC(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkValue("rs_oor_wait", txValidC, 1'b0);
    driveC(1'b1, OOR, 1'b0);
    tick();
    driveC(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    checkValue("rs_no_early_done", doneC, 1'b0);
    checkValue("rs_no_resp", txValidC, 1'b0);
    checkValue("rs_drained", expCodes.size(), 0);
    startC = 1'b0;
    tick();

    // ---------------- reset in DONE_TX ----------------
    expCodes.push_back(OOR);
    startC = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      case (e)
        2:       driveC(1'b0, 8'h00, 1'b1);
        3:       driveC(1'b1, OOR, 1'b0);
        default: driveC(1'b1, BOGUS, 1'b0);
      endcase
      if (e == 4) readyC = 1'b0;
      tick();
    end
    driveC(1'b1, BOGUS, 1'b0);
    checkValue("rd_req_offered", txValidC, 1'b1);
    checkValue("rd_req_code", txCodeC, REQ);
    #2;
    reset = 1'b1;
    #1;
    checkValue("rd_async_valid", txValidC, 1'b0);
    checkValue("rd_async_code", txCodeC, 8'h00);
    checkValue("rd_async_pat", patEnC, 1'b0);
    checkValue("rd_async_done", doneC, 1'b0);
    checkValue("rd_drained", expCodes.size(), 0);
    tick();
    reset  = 1'b0;
    readyC = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkValue("rd_bogus_pat", patEnC, 1'b1);
      checkValue("rd_bogus_valid", txValidC, 1'b0);
    end
    driveC(1'b0, 8'h00, 1'b0);
    startC = 1'b0;
    tick();

    // ---------------- timeout with TIMEOUT_CYCLES = 100 ----------------
    startT = 1'b1;
    firstT = 0;
    for (int e = 1; e <= 150 && firstT == 0; e++) begin
      tick();
      if (timeoutT) firstT = e;
    end
    checkValue("to_cycle", firstT, 100);
    checkValue("to_pat_off", patEnT, 1'b0);
    checkValue("to_done_off", doneT, 1'b0);
    tick(); tick();
    checkValue("to_held", timeoutT, 1'b1);
    startT = 1'b0;
    tick();
    checkValue("to_cleared", timeoutT, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
